// File: rtl/ifu_pkg.sv
// Shared defaults and the response-entry layout for the instruction-fetch responder.
package ifu_pkg;

  localparam int          IFU_ADDR_W    = 32;
  localparam int          IFU_MEM_AW    = 12;
  localparam logic [31:0] IFU_NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]           instr;
    logic [IFU_ADDR_W-1:0] addr;
    logic                  err;
  } ifu_rsp_t;

endpackage

// File: rtl/ifetch_rsp_fifo.sv
// Two-entry response FIFO with a synchronous clear; clear beats push and pop.
module ifetch_rsp_fifo
  import ifu_pkg::*;
#(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic [1:0]   count
);

  logic [W-1:0] ent_q [2];
  logic [W-1:0] ent_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  always_comb begin
    ent_d    = ent_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop & (count_q != 2'd0);
    do_push  = push & ((count_q != 2'd2) | do_pop);
    if (clr) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        ent_d[wr_ptr_q] = wdata;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      ent_q[0] <= ent_d[0];
      ent_q[1] <= ent_d[1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = ent_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ifetch_responder.sv
// Instruction-fetch responder: accept a PC, read the ITCM, return words in order
// through a two-entry FIFO; a flush drops everything outstanding.
module ifetch_responder
  import ifu_pkg::*;
#(
  parameter int          ADDR_W    = IFU_ADDR_W,
  parameter int          MEM_AW    = IFU_MEM_AW,
  parameter logic [31:0] NOP_INSTR = IFU_NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_vld,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_rdy,
  input  logic              flush,
  output logic              rsp_vld,
  output logic [31:0]       rsp_instr,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  input  logic              rsp_rdy,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata
);

  localparam int EW = 32 + ADDR_W + 1;

  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              pend_err_q, pend_err_d;
  logic              req_err, accept, do_pop, push;
  logic [1:0]        count;
  logic [2:0]        occ;
  logic [EW-1:0]     fifo_wdata, fifo_rdata;

  // S0: error check, credit and SRAM launch
  always_comb begin
    req_err  = (|req_addr[1:0]) | (|req_addr[ADDR_W-1:MEM_AW+2]);
    do_pop   = rsp_rdy & (count != 2'd0);
    // Counting this cycle's pop keeps one request per cycle flowing while the consumer is ready.
    occ      = {1'b0, count} + {2'b00, pend_q} - {2'b00, do_pop};
    req_rdy  = ~rst & ~flush & (occ < 3'd2);
    accept   = req_vld & req_rdy;
    mem_en   = accept & ~req_err;
    mem_addr = req_addr[MEM_AW+1:2];

    pend_d      = accept & ~flush;
    pend_addr_d = accept ? req_addr : pend_addr_q;
    pend_err_d  = accept ? req_err  : pend_err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_err_q  <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_err_q  <= pend_err_d;
    end
  end

  // S1: capture the SRAM word (or NOP for a faulting fetch) into the FIFO
  always_comb begin
    push       = pend_q & ~flush;
    fifo_wdata = {(pend_err_q ? NOP_INSTR : mem_rdata), pend_addr_q, pend_err_q};
  end

  ifetch_rsp_fifo #(
    .W (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (do_pop),
    .rdata (fifo_rdata),
    .count (count)
  );

  assign rsp_vld   = (count != 2'd0);
  assign rsp_instr = fifo_rdata[EW-1 -: 32];
  assign rsp_addr  = fifo_rdata[ADDR_W:1];
  assign rsp_err   = fifo_rdata[0];

endmodule

// File: tb/tb_ifetch_responder.sv
// Directed bench for ifetch_responder: an ordered-queue reference model checked every
// cycle, plus literal expectations taken from hand-worked timelines.
module tb_ifetch_responder;
  import ifu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_vld, req_rdy, flush, rsp_vld, rsp_err, rsp_rdy, mem_en;
  logic [31:0] req_addr, rsp_instr, rsp_addr, mem_rdata;
  logic [11:0] mem_addr;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [31:0] sram [4096];
  ifu_rsp_t    mq [$];
  int          rq [$];

  always #5 clk = ~clk;

  ifetch_responder dut (
    .clk       (clk),
    .rst       (rst),
    .req_vld   (req_vld),
    .req_addr  (req_addr),
    .req_rdy   (req_rdy),
    .flush     (flush),
    .rsp_vld   (rsp_vld),
    .rsp_instr (rsp_instr),
    .rsp_addr  (rsp_addr),
    .rsp_err   (rsp_err),
    .rsp_rdy   (rsp_rdy),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  // Synchronous ITCM: garbage unless a read was launched, so NOP substitution is observable.
  always @(posedge clk) mem_rdata <= mem_en ? sram[mem_addr] : 32'hDEAD_BEEF;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic bit bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'h0000_4000);
  endfunction

  // A response is visible two cycles after the cycle it was accepted in.
  function automatic bit m_vld();
    if (rst || mq.size() == 0) return 1'b0;
    return rq[0] <= cyc;
  endfunction

  // At most two responses may be owed to the consumer after this cycle.
  function automatic bit m_rdy();
    int owed;
    owed = mq.size() - ((m_vld() && rsp_rdy) ? 1 : 0);
    return !rst && !flush && (owed < 2);
  endfunction

  initial begin
    ifu_rsp_t e;
    bit acc, pop;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        rq.delete();
      end else begin
        acc = req_vld && m_rdy();
        pop = m_vld() && rsp_rdy;
        if (flush) begin
          mq.delete();
          rq.delete();
        end else begin
          if (pop) begin
            void'(mq.pop_front());
            void'(rq.pop_front());
          end
          if (acc) begin
            e.err   = bad_addr(req_addr);
            e.addr  = req_addr;
            e.instr = e.err ? 32'h0000_0013 : sram[req_addr[13:2]];
            mq.push_back(e);
            rq.push_back(cyc + 2);
          end
        end
        cyc++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("rsp_vld", rsp_vld, m_vld());
      check("req_rdy", req_rdy, m_rdy());
      check("mem_en", mem_en, req_vld && m_rdy() && !bad_addr(req_addr));
      if (mem_en) check("mem_addr", mem_addr, req_addr[13:2]);
      if (m_vld()) begin
        check("rsp_instr", rsp_instr, mq[0].instr);
        check("rsp_addr", rsp_addr, mq[0].addr);
        check("rsp_err", rsp_err, mq[0].err);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a);
    req_vld  = v;
    req_addr = a;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) sram[i] = 32'hAAAA_0000 | (i + 1);
    drive(1'b0, 32'h0);
    flush   = 1'b0;
    rsp_rdy = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    check("reset rsp_vld", rsp_vld, 0);
    check("reset rsp_instr", rsp_instr, 0);
    check("reset rsp_addr", rsp_addr, 0);
    check("reset rsp_err", rsp_err, 0);
    check("reset mem_en", mem_en, 0);

    // Back-to-back fetch with the consumer ready
    drive(1'b1, 32'h0); #1;
    check("b2b rdy0", req_rdy, 1);
    check("b2b mem_en0", mem_en, 1);
    step();
    drive(1'b1, 32'h4); #1;
    check("b2b rdy1", req_rdy, 1);
    step();
    drive(1'b1, 32'h8); #1;
    check("b2b rdy2", req_rdy, 1);
    check("b2b vld0", rsp_vld, 1);
    check("b2b addr0", rsp_addr, 32'h0);
    check("b2b instr0", rsp_instr, 32'hAAAA_0001);
    step();
    drive(1'b0, 32'h0); #1;
    check("b2b addr1", rsp_addr, 32'h4);
    check("b2b instr1", rsp_instr, 32'hAAAA_0002);
    step();
    check("b2b addr2", rsp_addr, 32'h8);
    check("b2b instr2", rsp_instr, 32'hAAAA_0003);
    step();
    check("b2b drained", rsp_vld, 0);

    // Backpressure: third request stalls until the consumer drains
    rsp_rdy = 1'b0;
    drive(1'b1, 32'h10); step();
    drive(1'b1, 32'h14); step();
    drive(1'b1, 32'h18); #1;
    check("bp stall", req_rdy, 0);
    step();
    step();
    check("bp head", rsp_addr, 32'h10);
    rsp_rdy = 1'b1; #1;
    check("bp rdy on pop", req_rdy, 1);
    step();
    drive(1'b0, 32'h0); #1;
    check("bp addr1", rsp_addr, 32'h14);
    step();
    check("bp addr2", rsp_addr, 32'h18);
    check("bp instr2", rsp_instr, 32'hAAAA_0007);
    step();
    check("bp drained", rsp_vld, 0);

    // Misaligned fetch between two good ones
    drive(1'b1, 32'h4); step();
    drive(1'b1, 32'h6); #1;
    check("mis mem_en", mem_en, 0);
    step();
    drive(1'b1, 32'h8); step();
    drive(1'b0, 32'h0); #1;
    check("mis addr", rsp_addr, 32'h6);
    check("mis err", rsp_err, 1);
    check("mis instr", rsp_instr, 32'h0000_0013);
    step();
    check("mis next", rsp_addr, 32'h8);
    check("mis next err", rsp_err, 0);
    step();

    // Out-of-range fetch
    drive(1'b1, 32'h4000); #1;
    check("oor mem_en", mem_en, 0);
    step();
    drive(1'b0, 32'h0); step();
    check("oor err", rsp_err, 1);
    check("oor instr", rsp_instr, 32'h0000_0013);
    check("oor addr", rsp_addr, 32'h4000);
    step();

    // Flush with one buffered and one pending, while a new request is offered
    rsp_rdy = 1'b0;
    drive(1'b1, 32'h20); step();
    drive(1'b1, 32'h24); step();
    drive(1'b1, 32'h28);
    flush = 1'b1; #1;
    check("flush no accept", req_rdy, 0);
    check("flush mem_en", mem_en, 0);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0); #1;
    check("flush vld", rsp_vld, 0);
    check("flush rdy", req_rdy, 1);
    rsp_rdy = 1'b1;
    drive(1'b1, 32'h100); step();
    drive(1'b0, 32'h0); step();
    check("flush new addr", rsp_addr, 32'h100);
    check("flush new instr", rsp_instr, 32'hAAAA_0041);
    step();
    check("flush only new", rsp_vld, 0);

    // Asynchronous reset with two entries buffered
    rsp_rdy = 1'b0;
    drive(1'b1, 32'h30); step();
    drive(1'b1, 32'h34); step();
    drive(1'b0, 32'h0); step();
    check("rst pre full", rsp_vld, 1);
    drive(1'b1, 32'h38);
    #2 rst = 1'b1;
    #1;
    check("rst async vld", rsp_vld, 0);
    check("rst async mem_en", mem_en, 0);
    check("rst async rdy", req_rdy, 0);
    step();
    rst = 1'b0;
    drive(1'b0, 32'h0);
    rsp_rdy = 1'b1;
    step();
    drive(1'b1, 32'h0); #1;
    check("cold rdy", req_rdy, 1);
    check("cold mem_en", mem_en, 1);
    step();
    drive(1'b0, 32'h0); step();
    check("cold vld", rsp_vld, 1);
    check("cold addr", rsp_addr, 32'h0);
    check("cold instr", rsp_instr, 32'hAAAA_0001);
    step();
    check("cold drained", rsp_vld, 0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
